bw_clk_cken_seq: RTL and testbench
==================================

# bw_clk_cken_seq

Staggered power-up/power-down sequencer for the cluster clock headers on the DRAM/DDR clock tree. It turns on each cluster's `cluster_cken` one at a time to limit di/dt, holds global reset and debug-init across the headers for a programmed time, and releases them together. It can tear the sequence down in reverse order and can issue debug-init pulses while running. It sits in the clock control unit, driving the `cluster_cken`, `grst_l` and `gdbginit_l` inputs of every cluster header it owns.

## Interface
- `NUM_CL`, default 4: number of cluster headers sequenced (1..16).
- `STAGGER`, default 8: gclk cycles between successive cken edges (≥1).
- `RST_HOLD`, default 16: gclk cycles `grst_l` stays low after the last cken rises (≥1).
- `DBG_HOLD`, default 4: gclk cycles of a debug-init pulse (≥1).
- `gclk`, input, 1: the single clock.
- `grst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: power-up request, sampled only in IDLE.
- `stop`, input, 1: power-down request, honoured in ON, HOLD and RUN.
- `dbg_req`, input, 1: debug-init request, honoured only in RUN.
- `cl_mask`, input, NUM_CL: clusters to sequence; captured on an accepted `start`.
- `cluster_cken`, output, NUM_CL: per-header clock enable.
- `grst_l`, output, 1: global reset to the headers, active-low.
- `gdbginit_l`, output, 1: debug init to the headers, active-low.
- `busy`, output, 1: high in every state except IDLE and RUN.
- `done`, output, 1: one-cycle pulse on entry to RUN.

## Operation
- States: IDLE, ON, HOLD, RUN, DBG, OFF.
- All outputs are registered.
- **Reset** (`grst`=1):
  - State goes to IDLE.
  - `cluster_cken`=0, `grst_l`=0, `gdbginit_l`=0, `busy`=0, `done`=0.
  - Captured mask and timer clear.
- **IDLE**:
  - `start`=1 with `cl_mask`≠0 and `stop`=0: capture the mask and go to ON.
  - `start` with `cl_mask`=0 is ignored.
  - `start` and `stop` together: `stop` wins, so the request is ignored.
- **ON**:
  - Enable the captured clusters in ascending index order. Masked-out indices are skipped and use no stagger slot.
  - After the last enable, wait STAGGER cycles, then go to HOLD.
- **HOLD**:
  - Count RST_HOLD cycles, then go to RUN.
  - On entry to RUN, `grst_l` and `gdbginit_l` both go to 1.
- **RUN**:
  - `stop` goes to OFF.
  - Otherwise `dbg_req` goes to DBG.
  - If both arrive in the same cycle, `stop` wins.
- **DBG**:
  - `gdbginit_l`=0 for DBG_HOLD cycles, then return to RUN. No `done` pulse on this return.
  - `stop` during DBG is latched and acted on when DBG finishes.
  - `dbg_req` during DBG is ignored.
- **OFF**:
  - First cycle: `grst_l`=0 and `gdbginit_l`=0.
  - Then disable the currently enabled clusters in descending index order, one every STAGGER cycles.
  - STAGGER cycles after the last disable, go to IDLE.
- **Stop during ON or HOLD**: abort and go to OFF, disabling only the clusters enabled so far.
- `cl_mask` changes after capture have no effect until the next accepted `start`.

## Timing
- `start` accepted at cycle t: the first enabled cluster's cken rises at t+1.
- Each following enabled cluster rises STAGGER cycles after the previous one.
- k = number of set bits in the captured mask. The last cken rises at t+1+(k−1)·STAGGER.
- Transitions to HOLD at last cken + STAGGER.
- `grst_l`, `gdbginit_l` rise and `done` pulses at last cken + STAGGER + RST_HOLD.
- `dbg_req` accepted at cycle d: `gdbginit_l` is low on cycles d+1 through d+DBG_HOLD.
- `stop` accepted at cycle s: `grst_l` falls at s+1, the first cken falls at s+1+STAGGER, and each later cken falls STAGGER cycles after the previous one.
- Worst-case timer width: clog2(max(STAGGER, RST_HOLD, DBG_HOLD)+1) bits. Cluster index width: clog2(NUM_CL).

## Configuration
- Macro: `BW_CLK_CKEN_SEQ_DBG_EN`.
- **Defined**: DBG state and `dbg_req` behave as described above.
- **Undefined**:
  - DBG state and its counter logic are not built.
  - `dbg_req` is ignored.
  - `gdbginit_l` tracks `grst_l` exactly.

## Structure
- Package `bw_clk_seq_pkg`:
  - State enum `cken_seq_state_t`.
  - Width helper constants.
  - `CL_MAX`=16.
- Sub-module `bw_clk_seq_timer`: loadable down-counter with a `load` input, a value input, and an `expire` pulse. It is shared by the stagger, RST_HOLD and DBG_HOLD intervals, since only one is active at a time.

## Test plan
- Parameters for the scenarios below: NUM_CL=4, STAGGER=8, RST_HOLD=16, DBG_HOLD=4.
- **Full power-up**: `cl_mask`=4'b1111, `start` at cycle 10 -> cken[0..3] rise at cycles 11/19/27/35; `grst_l`, `gdbginit_l` rise and `done` pulses at cycle 59.
- **Sparse mask**: `cl_mask`=4'b1010 -> cken[1] rises at 11 and cken[3] at 19; cken[0] and cken[2] stay 0; `done` at 43.
- **Abort mid-ON**: `stop` at cycle 20 after the full-mask start -> `grst_l` stays 0; cken[1] falls at 29, cken[0] at 37; IDLE at 45; cken[2] never rises.
- **Debug pulse**: `dbg_req` at cycle 70 in RUN -> `gdbginit_l`=0 on cycles 71–74; `grst_l` stays 1; no `done` pulse. With the macro undefined, `gdbginit_l` stays 1.
- **Simultaneous events**:
  - `dbg_req` and `stop` together in RUN -> OFF entered, no debug pulse.
  - `start` and `stop` together in IDLE -> stays IDLE.
  - `start` with `cl_mask`=0 -> stays IDLE.
- **Reset mid-operation**: `grst`=1 during OFF -> next cycle all cken=0, `grst_l`=0, `busy`=0, state IDLE.

Source files
------------

// File: rtl/bw_clk_seq_pkg.sv
// Shared types and helpers for the cluster clock-enable sequencer.
package bw_clk_seq_pkg;

  localparam int unsigned CL_MAX = 16;

  typedef enum logic [2:0] {
    StIdle,
    StOn,
    StHold,
    StRun,
    StDbg,
    StOff
  } cken_seq_state_t;

  // Bits needed for the shared interval timer to hold the longest interval.
  function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  // One-hot of the lowest set bit (zero when none set).
  function automatic logic [CL_MAX-1:0] lowest_bit(input logic [CL_MAX-1:0] v);
    return v & (~v + CL_MAX'(1));
  endfunction

  // One-hot of the highest set bit (zero when none set).
  function automatic logic [CL_MAX-1:0] highest_bit(input logic [CL_MAX-1:0] v);
    logic [CL_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < CL_MAX; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bw_clk_seq_timer.sv
// Loadable down-counter; o_expire is high during the last cycle of a loaded interval.
module bw_clk_seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Loading V at edge t makes expire high in cycle t+V.
  assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/bw_clk_cken_seq.sv
// Staggered power-up/power-down sequencer for cluster clock headers.
// Optional debug-init pulses are built when BW_CLK_CKEN_SEQ_DBG_EN is defined;
// otherwise gdbginit_l follows grst_l.
module bw_clk_cken_seq
  import bw_clk_seq_pkg::*;
#(
  parameter int unsigned NUM_CL   = 4,
  parameter int unsigned STAGGER  = 8,
  parameter int unsigned RST_HOLD = 16,
  parameter int unsigned DBG_HOLD = 4
) (
  input  logic              i_gclk,
  input  logic              i_grst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_dbg_req,
  input  logic [NUM_CL-1:0] i_cl_mask,
  output logic [NUM_CL-1:0] o_cluster_cken,
  output logic              o_grst_l,
  output logic              o_gdbginit_l,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned TW = tmr_width(STAGGER, RST_HOLD, DBG_HOLD);
  localparam logic [TW-1:0] LdStagger = TW'(STAGGER);
  localparam logic [TW-1:0] LdRstHold = TW'(RST_HOLD);

  cken_seq_state_t   r_state, w_state_d;
  logic [NUM_CL-1:0] r_cken, w_cken_d;
  logic [NUM_CL-1:0] r_pend, w_pend_d;   // captured clusters not yet enabled
  logic              r_grst_l, w_grst_l_d;
  logic              r_dbginit_l, w_dbginit_l_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              w_go_off;
  logic              w_load;
  logic [TW-1:0]     w_load_val;
  logic              w_expire;
  logic [NUM_CL-1:0] w_mask_low, w_pend_low, w_cken_high;

`ifdef BW_CLK_CKEN_SEQ_DBG_EN
  localparam logic [TW-1:0] LdDbgHold = TW'(DBG_HOLD);
  logic r_dbg_stop, w_dbg_stop_d;  // stop seen during a debug pulse
`else
  logic w_unused_dbg;
  assign w_unused_dbg = i_dbg_req;
`endif

  assign w_mask_low  = NUM_CL'(lowest_bit(CL_MAX'(i_cl_mask)));
  assign w_pend_low  = NUM_CL'(lowest_bit(CL_MAX'(r_pend)));
  assign w_cken_high = NUM_CL'(highest_bit(CL_MAX'(r_cken)));

  bw_clk_seq_timer #(
    .W(TW)
  ) u_timer (
    .i_clk   (i_gclk),
    .i_rst   (i_grst),
    .i_load  (w_load),
    .i_val   (w_load_val),
    .o_expire(w_expire)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_d     = r_state;
    w_cken_d      = r_cken;
    w_pend_d      = r_pend;
    w_grst_l_d    = r_grst_l;
    w_dbginit_l_d = r_dbginit_l;
    w_done_d      = 1'b0;
    w_go_off      = 1'b0;
    w_load        = 1'b0;
    w_load_val    = LdStagger;
`ifdef BW_CLK_CKEN_SEQ_DBG_EN
    w_dbg_stop_d  = r_dbg_stop;
`endif
    unique case (r_state)
      StIdle: begin
        // First cluster is enabled on the accepting edge.
        if (i_start && !i_stop && (i_cl_mask != '0)) begin
          w_state_d = StOn;
          w_cken_d  = w_mask_low;
          w_pend_d  = i_cl_mask & ~w_mask_low;
          w_load    = 1'b1;
        end
      end
      StOn: begin
        if (i_stop) begin
          w_go_off = 1'b1;
        end else if (w_expire) begin
          w_load = 1'b1;
          if (r_pend != '0) begin
            w_cken_d = r_cken | w_pend_low;
            w_pend_d = r_pend & ~w_pend_low;
          end else begin
            w_state_d  = StHold;
            w_load_val = LdRstHold;
          end
        end
      end
      StHold: begin
        if (i_stop) begin
          w_go_off = 1'b1;
        end else if (w_expire) begin
          w_state_d     = StRun;
          w_grst_l_d    = 1'b1;
          w_dbginit_l_d = 1'b1;
          w_done_d      = 1'b1;
        end
      end
      StRun: begin
        if (i_stop) begin
          w_go_off = 1'b1;
        end
`ifdef BW_CLK_CKEN_SEQ_DBG_EN
        else if (i_dbg_req) begin
          w_state_d     = StDbg;
          w_dbginit_l_d = 1'b0;
          w_load        = 1'b1;
          w_load_val    = LdDbgHold;
          w_dbg_stop_d  = 1'b0;
        end
`endif
      end
      StDbg: begin
`ifdef BW_CLK_CKEN_SEQ_DBG_EN
        if (i_stop) w_dbg_stop_d = 1'b1;
        if (w_expire) begin
          if (r_dbg_stop || i_stop) begin
            w_go_off = 1'b1;
          end else begin
            w_state_d     = StRun;
            w_dbginit_l_d = 1'b1;
          end
        end
`else
        w_state_d = StIdle;
`endif
      end
      StOff: begin
        if (w_expire) begin
          if (r_cken != '0) begin
            w_cken_d = r_cken & ~w_cken_high;
            w_load   = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Teardown: assert resets now, first disable one stagger later.
    if (w_go_off) begin
      w_state_d     = StOff;
      w_grst_l_d    = 1'b0;
      w_dbginit_l_d = 1'b0;
      w_pend_d      = '0;
      w_load        = 1'b1;
      w_load_val    = LdStagger;
    end
  end

  assign w_busy_d = (w_state_d != StIdle) && (w_state_d != StRun);

  // State and registered outputs.
  always_ff @(posedge i_gclk) begin
    if (i_grst) begin
      r_state     <= StIdle;
      r_cken      <= '0;
      r_pend      <= '0;
      r_grst_l    <= 1'b0;
      r_dbginit_l <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cken      <= w_cken_d;
      r_pend      <= w_pend_d;
      r_grst_l    <= w_grst_l_d;
      r_dbginit_l <= w_dbginit_l_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

`ifdef BW_CLK_CKEN_SEQ_DBG_EN
  // Latched stop request for the end of a debug pulse.
  always_ff @(posedge i_gclk) begin
    if (i_grst) r_dbg_stop <= 1'b0;
    else        r_dbg_stop <= w_dbg_stop_d;
  end
`endif

  assign o_cluster_cken = r_cken;
  assign o_grst_l       = r_grst_l;
  assign o_gdbginit_l   = r_dbginit_l;  // equals r_grst_l when debug is not built
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_bw_clk_cken_seq.sv
// Table-driven bench with a cycle-stamped scoreboard for bw_clk_cken_seq.
module tb_bw_clk_cken_seq;

`ifdef BW_CLK_CKEN_SEQ_DBG_EN
  localparam logic DBG = 1'b1;
`else
  localparam logic DBG = 1'b0;
`endif

  localparam int KRst = 0;
  localparam int KDrv = 1;
  localparam int KChk = 2;

  logic       clk = 1'b0;
  logic       grst, start, stop, dbg;
  logic [3:0] mask;
  logic [3:0] cken;
  logic       grst_l, gdbg_l, busy, done;

  int cyc  = 0;
  int base = 0;
  int n_chk  = 0;
  int n_pass = 0;

  // Expected packing: {cken[3:0], grst_l, gdbginit_l, busy, done}
  typedef struct {
    int         kind;
    int         at;
    logic       rs, st, sp, db;
    logic [3:0] m;
    logic [7:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bw_clk_cken_seq #(
    .NUM_CL  (4),
    .STAGGER (8),
    .RST_HOLD(16),
    .DBG_HOLD(4)
  ) dut (
    .i_gclk        (clk),
    .i_grst        (grst),
    .i_start       (start),
    .i_stop        (stop),
    .i_dbg_req     (dbg),
    .i_cl_mask     (mask),
    .o_cluster_cken(cken),
    .o_grst_l      (grst_l),
    .o_gdbginit_l  (gdbg_l),
    .o_busy        (busy),
    .o_done        (done)
  );

  function automatic vec_t mk_rst();
    vec_t v;
    v.kind = KRst; v.at = 0; v.rs = 0; v.st = 0; v.sp = 0; v.db = 0; v.m = '0;
    v.exp = '0; v.name = "reset";
    return v;
  endfunction

  function automatic vec_t mk_drv(int at, logic rs, logic st, logic sp, logic db,
                                  logic [3:0] m);
    vec_t v;
    v.kind = KDrv; v.at = at; v.rs = rs; v.st = st; v.sp = sp; v.db = db; v.m = m;
    v.exp = '0; v.name = "drive";
    return v;
  endfunction

  function automatic vec_t mk_chk(int at, logic [3:0] ck, logic gr, logic dg, logic bz,
                                  logic dn, string nm);
    vec_t v;
    v.kind = KChk; v.at = at; v.rs = 0; v.st = 0; v.sp = 0; v.db = 0; v.m = '0;
    v.exp = {ck, gr, dg, bz, dn}; v.name = nm;
    return v;
  endfunction

  task automatic compare(input string nm, input int rel, input logic [7:0] act,
                         input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s rel_cycle=%0d got cken=%b grst_l=%b gdbginit_l=%b busy=%b done=%b, want cken=%b grst_l=%b gdbginit_l=%b busy=%b done=%b",
                  nm, rel, act[7:4], act[3], act[2], act[1], act[0],
                  exp[7:4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  task automatic flush_sb();
    foreach (sbq[i]) begin
      n_chk++;
      $display("FAIL %s never compared (due rel_cycle %0d)", sbq[i].name, sbq[i].cyc);
    end
    sbq.delete();
  endtask

  task automatic clear_pulses();
    grst = 1'b0; start = 1'b0; stop = 1'b0; dbg = 1'b0;
  endtask

  task automatic wait_rel(input int x);
    while (cyc - base < x) begin
      @(negedge clk);
      clear_pulses();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    grst = 1'b1; start = 1'b0; stop = 1'b0; dbg = 1'b0; mask = '0;
    @(negedge clk);
    compare("reset_state", cyc - base, {cken, grst_l, gdbg_l, busy, done}, 8'h00);
    grst = 1'b0;
    flush_sb();
    base = cyc;
  endtask

  // Scoreboard monitor: compare every entry due in the current cycle.
  always @(negedge clk) begin
    int rel;
    rel = cyc - base;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == rel) begin
        compare(sbq[i].name, rel, {cken, grst_l, gdbg_l, busy, done}, sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  initial begin
    sb_t e;
    grst = 1'b1; start = 1'b0; stop = 1'b0; dbg = 1'b0; mask = '0;

    // Full power-up, debug pulse, then dbg_req+stop together in RUN.
    tbl.push_back(mk_rst());
    tbl.push_back(mk_chk(5,   4'b0000, 0, 0, 0, 0, "idle_before_start"));
    tbl.push_back(mk_drv(10,  0, 1, 0, 0, 4'b1111));
    tbl.push_back(mk_chk(11,  4'b0001, 0, 0, 1, 0, "cken0_rise"));
    tbl.push_back(mk_chk(18,  4'b0001, 0, 0, 1, 0, "cken1_not_yet"));
    tbl.push_back(mk_chk(19,  4'b0011, 0, 0, 1, 0, "cken1_rise"));
    tbl.push_back(mk_chk(27,  4'b0111, 0, 0, 1, 0, "cken2_rise"));
    tbl.push_back(mk_chk(35,  4'b1111, 0, 0, 1, 0, "cken3_rise"));
    tbl.push_back(mk_chk(43,  4'b1111, 0, 0, 1, 0, "hold"));
    tbl.push_back(mk_chk(58,  4'b1111, 0, 0, 1, 0, "hold_last"));
    tbl.push_back(mk_chk(59,  4'b1111, 1, 1, 0, 1, "run_done"));
    tbl.push_back(mk_chk(60,  4'b1111, 1, 1, 0, 0, "done_one_cycle"));
    tbl.push_back(mk_drv(70,  0, 0, 0, 1, 4'b1111));
    tbl.push_back(mk_chk(71,  4'b1111, 1, ~DBG, DBG, 0, "dbg_first"));
    tbl.push_back(mk_chk(74,  4'b1111, 1, ~DBG, DBG, 0, "dbg_last"));
    tbl.push_back(mk_chk(75,  4'b1111, 1, 1, 0, 0, "dbg_release_no_done"));
    tbl.push_back(mk_drv(80,  0, 0, 1, 1, 4'b1111));
    tbl.push_back(mk_chk(81,  4'b1111, 0, 0, 1, 0, "stop_beats_dbg"));
    tbl.push_back(mk_chk(89,  4'b0111, 0, 0, 1, 0, "cken3_fall"));
    tbl.push_back(mk_chk(97,  4'b0011, 0, 0, 1, 0, "cken2_fall"));
    tbl.push_back(mk_chk(105, 4'b0001, 0, 0, 1, 0, "cken1_fall"));
    tbl.push_back(mk_chk(113, 4'b0000, 0, 0, 1, 0, "cken0_fall"));
    tbl.push_back(mk_chk(120, 4'b0000, 0, 0, 1, 0, "off_tail"));
    tbl.push_back(mk_chk(121, 4'b0000, 0, 0, 0, 0, "off_to_idle"));

    // Sparse mask; mask change after capture has no effect.
    tbl.push_back(mk_rst());
    tbl.push_back(mk_drv(10,  0, 1, 0, 0, 4'b1010));
    tbl.push_back(mk_chk(11,  4'b0010, 0, 0, 1, 0, "sparse_first"));
    tbl.push_back(mk_drv(12,  0, 0, 0, 0, 4'b0101));
    tbl.push_back(mk_chk(18,  4'b0010, 0, 0, 1, 0, "sparse_gap"));
    tbl.push_back(mk_chk(19,  4'b1010, 0, 0, 1, 0, "sparse_second"));
    tbl.push_back(mk_chk(42,  4'b1010, 0, 0, 1, 0, "sparse_hold_last"));
    tbl.push_back(mk_chk(43,  4'b1010, 1, 1, 0, 1, "sparse_done"));
    tbl.push_back(mk_chk(44,  4'b1010, 1, 1, 0, 0, "sparse_run"));

    // Abort during ON.
    tbl.push_back(mk_rst());
    tbl.push_back(mk_drv(10,  0, 1, 0, 0, 4'b1111));
    tbl.push_back(mk_drv(20,  0, 0, 1, 0, 4'b1111));
    tbl.push_back(mk_chk(21,  4'b0011, 0, 0, 1, 0, "abort_off"));
    tbl.push_back(mk_chk(28,  4'b0011, 0, 0, 1, 0, "abort_wait"));
    tbl.push_back(mk_chk(29,  4'b0001, 0, 0, 1, 0, "abort_cken1_fall"));
    tbl.push_back(mk_chk(37,  4'b0000, 0, 0, 1, 0, "abort_cken0_fall"));
    tbl.push_back(mk_chk(44,  4'b0000, 0, 0, 1, 0, "abort_tail"));
    tbl.push_back(mk_chk(45,  4'b0000, 0, 0, 0, 0, "abort_idle"));
    tbl.push_back(mk_chk(60,  4'b0000, 0, 0, 0, 0, "abort_stays_idle"));

    // IDLE corner cases, then a single-cluster power-up.
    tbl.push_back(mk_rst());
    tbl.push_back(mk_drv(5,   0, 1, 1, 0, 4'b1111));
    tbl.push_back(mk_chk(6,   4'b0000, 0, 0, 0, 0, "start_with_stop"));
    tbl.push_back(mk_drv(8,   0, 1, 0, 0, 4'b0000));
    tbl.push_back(mk_chk(9,   4'b0000, 0, 0, 0, 0, "start_zero_mask"));
    tbl.push_back(mk_drv(15,  0, 1, 0, 0, 4'b0100));
    tbl.push_back(mk_chk(16,  4'b0100, 0, 0, 1, 0, "single_rise"));
    tbl.push_back(mk_chk(39,  4'b0100, 0, 0, 1, 0, "single_hold_last"));
    tbl.push_back(mk_chk(40,  4'b0100, 1, 1, 0, 1, "single_done"));

    // Stop during a debug pulse, then reset in the middle of OFF.
    tbl.push_back(mk_rst());
    tbl.push_back(mk_drv(10,  0, 1, 0, 0, 4'b1111));
    tbl.push_back(mk_chk(59,  4'b1111, 1, 1, 0, 1, "run_done_2"));
    tbl.push_back(mk_drv(62,  0, 0, 0, 1, 4'b1111));
    tbl.push_back(mk_drv(63,  0, 0, 1, 0, 4'b1111));
    tbl.push_back(mk_chk(65,  4'b1111, DBG, 0, 1, 0, "stop_in_dbg"));
    tbl.push_back(mk_chk(67,  4'b1111, 0, 0, 1, 0, "off_after_dbg"));
    tbl.push_back(mk_chk(75,  4'b0111, 0, 0, 1, 0, "first_fall_after_dbg"));
    tbl.push_back(mk_drv(80,  1, 0, 0, 0, 4'b1111));
    tbl.push_back(mk_chk(81,  4'b0000, 0, 0, 0, 0, "reset_mid_off"));
    tbl.push_back(mk_chk(85,  4'b0000, 0, 0, 0, 0, "idle_after_reset"));

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        KRst: do_reset();
        KDrv: begin
          wait_rel(tbl[i].at);
          grst  = tbl[i].rs;
          start = tbl[i].st;
          stop  = tbl[i].sp;
          dbg   = tbl[i].db;
          mask  = tbl[i].m;
        end
        default: begin
          wait_rel(tbl[i].at - 1);
          e.cyc  = tbl[i].at;
          e.exp  = tbl[i].exp;
          e.name = tbl[i].name;
          sbq.push_back(e);
        end
      endcase
    end

    @(negedge clk);
    clear_pulses();
    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
    flush_sb();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
